// File: rtl/framebuffer_writer.sv
// framebuffer_writer
//   Burst-bus master that writes a rectangular pixel region into PSRAM, one
//   line at a time with a programmable line stride. A stream of 32-bit pixel
//   words is staged into aligned 8-word blocks, and each block is written as
//   one 4-beat x 64-bit write burst. Words of a block that the region does not
//   cover are byte-masked.
//
// Ports
//   clk_i, rst_n_i        system clock, asynchronous active-low reset
//   start_i               one-cycle pulse; latches the config below (ignored while busy)
//   base_addr_i [20:0]    word address of the first word of line 0
//   words_per_line_i[9:0] words per line (0 allowed)
//   stride_i [15:0]       word offset between consecutive line starts
//   lines_i [8:0]         number of lines (0 allowed)
//   pix_data_i/pix_valid_i/pix_ready_o   pixel word stream (valid/ready)
//   busy_o, done_o        job status; done_o pulses for one cycle
//   addr_o, cmd_o, cmd_en_o, wr_data_o, data_mask_o   burst bus master side
//
// State | meaning
//   S_IDLE | no burst in flight; start the oldest pending block when one exists
//   S_GAP  | enforcing CMD_GAP idle cycles after the last beat of a burst
//   S_B0   | command + beat 0 (words 0,1 of the block)
//   S_B1   | beat 1 (words 2,3)
//   S_B2   | beat 2 (words 4,5)
//   S_B3   | beat 3 (words 6,7); releases the block buffer
module framebuffer_writer #(
  parameter int unsigned CMD_GAP = 14
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [20:0] base_addr_i,
  input  logic [9:0]  words_per_line_i,
  input  logic [15:0] stride_i,
  input  logic [8:0]  lines_i,
  input  logic [31:0] pix_data_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [20:0] addr_o,
  output logic        cmd_o,
  output logic        cmd_en_o,
  output logic [63:0] wr_data_o,
  output logic [7:0]  data_mask_o
);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_B0, S_B1, S_B2, S_B3} state_e;

  state_e      state_q, state_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;

  // job configuration and line walker
  logic        busy_q, done_q;
  logic [9:0]  wpl_q;
  logic [15:0] stride_q;
  logic [8:0]  line_cnt_q;
  logic [20:0] line_addr_q;
  logic [9:0]  word_cnt_q;

  // two 8-word staging buffers; fill_sel_q receives words, iss_sel_q is the oldest hand-off
  logic [31:0] buf_data_q [2][8];
  logic [7:0]  buf_vld_q  [2];
  logic [17:0] buf_blk_q  [2];
  logic [1:0]  buf_pend_q;
  logic        fill_sel_q;
  logic        iss_sel_q;

  logic [20:0] word_addr;
  logic        words_left;
  logic        pix_ready;
  logic        accept;
  logic        last_word;
  logic        handoff;
  logic        skip_line;
  logic        release_buf;
  logic        bursting;
  logic        fin;
  logic        start_acc;
  logic [1:0]  beat_idx;

  assign word_addr   = line_addr_q + 21'(word_cnt_q);
  assign words_left  = (line_cnt_q != '0);
  assign pix_ready   = busy_q && words_left && (wpl_q != '0) && !buf_pend_q[fill_sel_q];
  assign accept      = pix_valid_i && pix_ready;
  assign last_word   = (word_cnt_q == wpl_q - 10'd1);
  // a block closes at its last slot or at end of line, so lines never share a block
  assign handoff     = accept && ((word_addr[2:0] == 3'b111) || last_word);
  assign skip_line   = busy_q && words_left && (wpl_q == '0);
  assign release_buf = (state_q == S_B3);
  assign bursting    = (state_q == S_B0) || (state_q == S_B1) ||
                       (state_q == S_B2) || (state_q == S_B3);
  assign start_acc   = start_i && !busy_q;
  // job completes when every line is consumed and the last pending block is on its final beat
  assign fin         = busy_q && !words_left &&
                       ((release_buf && !(&buf_pend_q)) || (!bursting && !(|buf_pend_q)));

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: if (buf_pend_q[iss_sel_q]) state_d = S_B0;
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = buf_pend_q[iss_sel_q] ? S_B0 : S_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 16'd1;
      end
      S_B0: state_d = S_B1;
      S_B1: state_d = S_B2;
      S_B2: state_d = S_B3;
      S_B3: begin
        if (fin || (CMD_GAP == 0)) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_GAP;
          gap_cnt_d = 16'(CMD_GAP - 1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wpl_q       <= '0;
      stride_q    <= '0;
      line_cnt_q  <= '0;
      line_addr_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      done_q <= fin || (start_acc && (lines_i == '0));
      if (start_acc) begin
        busy_q      <= (lines_i != '0);
        wpl_q       <= words_per_line_i;
        stride_q    <= stride_i;
        line_cnt_q  <= lines_i;
        line_addr_q <= base_addr_i;
        word_cnt_q  <= '0;
      end else if (fin) begin
        busy_q <= 1'b0;
      end
      if (accept) begin
        if (last_word) begin
          word_cnt_q  <= '0;
          line_addr_q <= line_addr_q + 21'(stride_q);
          line_cnt_q  <= line_cnt_q - 9'd1;
        end else begin
          word_cnt_q <= word_cnt_q + 10'd1;
        end
      end
      if (skip_line) begin
        line_addr_q <= line_addr_q + 21'(stride_q);
        line_cnt_q  <= line_cnt_q - 9'd1;
      end
    end
  end

  // release and fill always target different buffers (the released one is pending,
  // the filled one is not), so both updates land in the same cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < 8; w++) buf_data_q[b][w] <= '0;
        buf_vld_q[b] <= '0;
        buf_blk_q[b] <= '0;
      end
      buf_pend_q <= '0;
      fill_sel_q <= 1'b0;
      iss_sel_q  <= 1'b0;
    end else begin
      if (release_buf) begin
        buf_pend_q[iss_sel_q] <= 1'b0;
        buf_vld_q[iss_sel_q]  <= '0;
        iss_sel_q             <= ~iss_sel_q;
      end
      if (accept) begin
        buf_data_q[fill_sel_q][word_addr[2:0]] <= pix_data_i;
        buf_vld_q[fill_sel_q][word_addr[2:0]]  <= 1'b1;
        buf_blk_q[fill_sel_q]                  <= word_addr[20:3];
        if (handoff) begin
          buf_pend_q[fill_sel_q] <= 1'b1;
          fill_sel_q             <= ~fill_sel_q;
        end
      end
    end
  end

  always_comb begin
    beat_idx = 2'd0;
    case (state_q)
      S_B1:    beat_idx = 2'd1;
      S_B2:    beat_idx = 2'd2;
      S_B3:    beat_idx = 2'd3;
      default: beat_idx = 2'd0;
    endcase
  end

  always_comb begin
    addr_o      = '0;
    cmd_o       = 1'b0;
    cmd_en_o    = 1'b0;
    wr_data_o   = '0;
    data_mask_o = '0;
    if (state_q == S_B0) begin
      addr_o   = {buf_blk_q[iss_sel_q], 3'b000};
      cmd_o    = 1'b1;
      cmd_en_o = 1'b1;
    end
    if (bursting) begin
      // even word of the pair occupies the upper half of the beat
      wr_data_o   = {buf_data_q[iss_sel_q][{beat_idx, 1'b0}],
                     buf_data_q[iss_sel_q][{beat_idx, 1'b1}]};
      data_mask_o = {{4{~buf_vld_q[iss_sel_q][{beat_idx, 1'b0}]}},
                     {4{~buf_vld_q[iss_sel_q][{beat_idx, 1'b1}]}}};
    end
  end

  assign pix_ready_o = pix_ready;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
module tb_framebuffer_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [20:0] base_addr = '0;
  logic [9:0]  wpl = '0;
  logic [15:0] stride = '0;
  logic [8:0]  lines = '0;
  logic [31:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready, busy, done;
  logic [20:0] addr;
  logic        cmd, cmd_en;
  logic [63:0] wr_data;
  logic [7:0]  data_mask;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  framebuffer_writer #(.CMD_GAP(14)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .base_addr_i(base_addr),
    .words_per_line_i(wpl), .stride_i(stride), .lines_i(lines),
    .pix_data_i(pix_data), .pix_valid_i(pix_valid), .pix_ready_o(pix_ready),
    .busy_o(busy), .done_o(done), .addr_o(addr), .cmd_o(cmd), .cmd_en_o(cmd_en),
    .wr_data_o(wr_data), .data_mask_o(data_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // bus monitor: records every burst (command + 4 consecutive beats)
  logic [20:0] q_addr [$];
  logic        q_cmd  [$];
  int          q_b0   [$];
  logic [63:0] q_data [$];
  logic [7:0]  q_mask [$];
  int beat_n = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      beat_n = 0;
    end else begin
      if (cmd_en) begin
        q_addr.push_back(addr);
        q_cmd.push_back(cmd);
        q_b0.push_back(cyc);
        q_data.push_back(wr_data);
        q_mask.push_back(data_mask);
        beat_n = 1;
      end else if (beat_n > 0 && beat_n < 4) begin
        q_data.push_back(wr_data);
        q_mask.push_back(data_mask);
        beat_n++;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    q_addr.delete(); q_cmd.delete(); q_b0.delete(); q_data.delete(); q_mask.delete();
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start(input logic [20:0] b, input logic [9:0] w,
                          input logic [15:0] s, input logic [8:0] l);
    base_addr = b; wpl = w; stride = s; lines = l;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(input int n, input logic [31:0] first, output bit stalled);
    int i = 0;
    int budget = 0;
    bit rdy;
    stalled = 1'b0;
    pix_valid = 1'b1;
    pix_data = first;
    while (i < n && budget < 3000) begin
      rdy = pix_ready;
      tick(1);
      budget++;
      if (rdy) begin
        i++;
        pix_data = first + 32'(i);
      end else begin
        stalled = 1'b1;
      end
    end
    pix_valid = 1'b0;
    chk("send_words_accepted", 64'(i), 64'(n));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic run_t1(input string p);
    bit st;
    int d0;
    clear_mon();
    d0 = done_cnt;
    do_start(21'd0, 10'd8, 16'd0, 9'd1);
    chk({p, "_busy_after_start"}, 64'(busy), 64'd1);
    send(8, 32'd0, st);
    wait_done({p, "_done_seen"}, 200);
    chk({p, "_busy_after_done"}, 64'(busy), 64'd0);
    chk({p, "_done_pulse_low"}, 64'(done), 64'd0);
    chk({p, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    chk({p, "_nbursts"}, 64'(q_addr.size()), 64'd1);
    chk({p, "_addr"}, 64'(q_addr[0]), 64'd0);
    chk({p, "_cmd"}, 64'(q_cmd[0]), 64'd1);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] we, wo;
      we = 32'(2 * k);
      wo = 32'(2 * k + 1);
      chk($sformatf("%s_data%0d", p, k), q_data[k], {we, wo});
      chk($sformatf("%s_mask%0d", p, k), 64'(q_mask[k]), 64'h00);
    end
    chk({p, "_done_after_b3"}, 64'(last_done_cyc), 64'(q_b0[0] + 4));
  endtask

  initial begin
    bit st;
    int d0;
    logic [31:0] hi, lo;

    // reset
    tick(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pix_ready", 64'(pix_ready), 64'd0);
    chk("rst_cmd_en", 64'(cmd_en), 64'd0);
    chk("rst_cmd", 64'(cmd), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_mask", 64'(data_mask), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // idle: pixel stream ignored
    pix_valid = 1'b1;
    tick(2);
    chk("idle_pix_ready", 64'(pix_ready), 64'd0);
    pix_valid = 1'b0;

    // test 1: one aligned full block
    run_t1("t1");
    tick(5);

    // test 2: unaligned 4-word line spanning two blocks
    clear_mon();
    do_start(21'd5, 10'd4, 16'd0, 9'd1);
    send(4, 32'h0A0A_0000, st);
    wait_done("t2_done_seen", 300);
    chk("t2_nbursts", 64'(q_addr.size()), 64'd2);
    chk("t2_addr0", 64'(q_addr[0]), 64'd0);
    chk("t2_mask0", 64'(q_mask[0]), 64'hFF);
    chk("t2_mask1", 64'(q_mask[1]), 64'hFF);
    chk("t2_mask2", 64'(q_mask[2]), 64'hF0);
    chk("t2_mask3", 64'(q_mask[3]), 64'h00);
    chk("t2_beat2_lo", 64'(q_data[2][31:0]), 64'h0A0A_0000);
    chk("t2_beat3", q_data[3], 64'h0A0A_0001_0A0A_0002);
    chk("t2_addr1", 64'(q_addr[1]), 64'd8);
    chk("t2_b1beat0_hi", 64'(q_data[4][63:32]), 64'h0A0A_0003);
    chk("t2_b1mask0", 64'(q_mask[4]), 64'h0F);
    chk("t2_b1mask1", 64'(q_mask[5]), 64'hFF);
    chk("t2_b1mask2", 64'(q_mask[6]), 64'hFF);
    chk("t2_b1mask3", 64'(q_mask[7]), 64'hFF);
    tick(5);

    // test 3: three short lines at stride 16, plus an ignored start while busy
    clear_mon();
    d0 = done_cnt;
    do_start(21'd0, 10'd2, 16'd16, 9'd3);
    send(6, 32'h0000_0300, st);
    chk("t3_busy_before_restart", 64'(busy), 64'd1);
    do_start(21'd100, 10'd8, 16'd0, 9'd1);
    wait_done("t3_done_seen", 500);
    tick(40);
    chk("t3_nbursts", 64'(q_addr.size()), 64'd3);
    chk("t3_done_count", 64'(done_cnt - d0), 64'd1);
    for (int k = 0; k < 3; k++) begin
      hi = 32'h300 + 32'(2 * k);
      lo = 32'h301 + 32'(2 * k);
      chk($sformatf("t3_addr%0d", k), 64'(q_addr[k]), 64'(16 * k));
      chk($sformatf("t3_data%0d", k), q_data[4 * k], {hi, lo});
      chk($sformatf("t3_mask%0d_0", k), 64'(q_mask[4 * k]), 64'h00);
      chk($sformatf("t3_mask%0d_1", k), 64'(q_mask[4 * k + 1]), 64'hFF);
      chk($sformatf("t3_mask%0d_2", k), 64'(q_mask[4 * k + 2]), 64'hFF);
      chk($sformatf("t3_mask%0d_3", k), 64'(q_mask[4 * k + 3]), 64'hFF);
    end
    for (int k = 0; k < 2; k++)
      chk($sformatf("t3_gap%0d", k), 64'((q_b0[k + 1] - q_b0[k]) >= 18), 64'd1);

    // test 4: 32 words back-to-back, both buffers fill up
    clear_mon();
    do_start(21'd0, 10'd32, 16'd0, 9'd1);
    send(32, 32'h4000_0000, st);
    chk("t4_backpressure", 64'(st), 64'd1);
    wait_done("t4_done_seen", 500);
    chk("t4_nbursts", 64'(q_addr.size()), 64'd4);
    chk("t4_nbeats", 64'(q_data.size()), 64'd16);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("t4_addr%0d", b), 64'(q_addr[b]), 64'(8 * b));
      for (int k = 0; k < 4; k++) begin
        hi = 32'h4000_0000 + 32'(8 * b + 2 * k);
        lo = 32'h4000_0000 + 32'(8 * b + 2 * k + 1);
        chk($sformatf("t4_data%0d_%0d", b, k), q_data[4 * b + k], {hi, lo});
        chk($sformatf("t4_mask%0d_%0d", b, k), 64'(q_mask[4 * b + k]), 64'h00);
      end
    end
    tick(5);

    // test 5: lines=0
    clear_mon();
    do_start(21'd7, 10'd4, 16'd0, 9'd0);
    chk("t5_done_pulse", 64'(done), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    tick(1);
    chk("t5_done_low", 64'(done), 64'd0);
    tick(20);
    chk("t5_no_cmd", 64'(q_addr.size()), 64'd0);

    // test 6: reset during beat 1, then a clean rerun of test 1
    clear_mon();
    do_start(21'd0, 10'd8, 16'd0, 9'd1);
    send(8, 32'd0, st);
    d0 = 0;
    while (!cmd_en && d0 < 50) begin
      tick(1);
      d0++;
    end
    chk("t6_cmd_seen", 64'(cmd_en), 64'd1);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cmd_en", 64'(cmd_en), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_pix_ready", 64'(pix_ready), 64'd0);
    chk("t6_rst_wr_data", wr_data, 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    run_t1("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
